sym_detect_sched: RTL
=====================

Name: sym_detect_sched

Overview:
- Controller that shares one pattern-matching datapath among NREQ symbol-stream requesters.
- Arbitrates round-robin and grants one requester at a time.
- Streams exactly FRAME_LEN symbols from the granted requester through a sliding-window matcher, then reports a per-session 2-bit result code tagged with the requester id.
- Sits between producer-side stream sources and the result-collection logic.

Parameters:
- NREQ, 4, number of requesters (2..8).
- SYM_W, 3, symbol width in bits.
- PAT_LEN, 4, pattern length in symbols.
- PATTERN, 12'b000_110_000_110, target sequence; oldest symbol in MSBs; width PAT_LEN*SYM_W.
- FRAME_LEN, 8, symbols per session (must be ≥ PAT_LEN, ≤ 255).
- TIMEOUT, 15, idle cycles tolerated while granted (1..255).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester session request, level.
- sym_in  in  NREQ*SYM_W  flattened symbols; requester i occupies bits [i*SYM_W +: SYM_W].
- sym_valid  in  NREQ  per-requester symbol valid.
- sym_ready  out  NREQ  per-requester ready; only the granted bit may be 1.
- grant  out  NREQ  one-hot grant; all-zero when idle.
- busy  out  1  high in RUN and REPORT.
- result_valid  out  1  one-cycle pulse.
- result_id  out  $clog2(NREQ)  requester served.
- result_code  out  2  00 no match; 01 aborted; 10 match, last symbol odd; 11 match, last symbol even.

Behaviour:
- Reset (async, rst=1):
  - State IDLE; grant, sym_ready, busy, result_valid = 0; result_id = 0; result_code = 00.
  - RR pointer = 0; counters = 0; matcher window and fill count cleared; hit flag cleared.
  - Reset asserted mid-session discards the session with no report.
- States: IDLE, RUN, REPORT. All outputs are registered except sym_ready, which equals grant & {NREQ{state==RUN}}.
- IDLE:
  - If any req is set, select the first set bit scanning from ptr upward with wrap.
  - Next cycle: state RUN, grant one-hot for the winner, sym_cnt = 0, idle_cnt = 0, matcher cleared, hit = 0.
  - Arbitration latency is 1 cycle from req to grant.
- RUN, granted index g:
  - Accept a symbol when sym_valid[g] is high: shift it into the window, increment sym_cnt and fill count (fill saturates at PAT_LEN), and clear idle_cnt.
  - No symbol accepted: increment idle_cnt.
  - Match: when fill == PAT_LEN after the shift and the window equals PATTERN, set hit (sticky). Overlapping occurrences are detected.
  - The matcher output is a function of the window contents including the symbol accepted that cycle.
  - Exit to REPORT when any of the following occurs:
    - (a) The FRAME_LEN-th symbol is accepted: code = hit(incl. this symbol) ? {1'b1, ~last_sym[0]} : 00.
    - (b) idle_cnt reaches TIMEOUT: code = 01.
    - (c) req[g] is low and no symbol is accepted that cycle: code = 01.
  - Priority: symbol acceptance beats timeout and req drop in the same cycle, so a final symbol with req low still completes normally.
  - Requests from other requesters are ignored while RUN; no preemption.
- REPORT (one cycle):
  - result_valid = 1, with result_id and result_code registered on entry.
  - grant and sym_ready = 0; ptr = (g+1) mod NREQ.
  - Next state IDLE. result_id and result_code hold their values until the next REPORT.
- Back-to-back: a requester holding req wins again only after every other active requester has been served once.
- Width rules:
  - sym_cnt and idle_cnt are 8-bit and never wrap; they are compared against parameters.
  - Odd/even is decided by bit 0 of the last accepted symbol.

Decomposition:
- Package sym_sched_pkg holds:
  - the state enum (IDLE/RUN/REPORT);
  - the result-code constants RES_NOMATCH = 2'b00, RES_ABORT = 2'b01, RES_ODD = 2'b10, RES_EVEN = 2'b11.
- Sub-module sym_window_matcher (params SYM_W, PAT_LEN, PATTERN):
  - Inputs: clk, rst, clr, shift_en, sym.
  - Outputs: match (combinational on the next-window value) and last_lsb.

Test Plan:
- Reset then req=0001; requester 0 sends 000,110,000,110,001,011,101,110 → grant 0001 one cycle after req; result_valid pulse, id 0, code 11 (last symbol 110 even).
- Same frame but final symbol 111 → code 10; frame 001×8 → code 00; pattern straddling 000,000,110,000,110 → hit detected, code per last symbol.
- req=1111 held, each requester sends 8 symbols with valid=1 → grants in order 0,1,2,3,0; each result_id matches its grant.
- Granted requester holds sym_valid low 15 cycles after 3 symbols → REPORT with code 01; next requester granted 1 cycle after REPORT.
- req dropped mid-frame, no valid → code 01. Last symbol with req low in the same cycle → normal code.
- rst asserted mid-RUN → grant, sym_ready and result_valid low immediately, no report; the next session arbitrates from ptr 0.

Source files
------------

// File: rtl/sym_detect_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sym_sched_pkg
// Description : Shared types and constants for the symbol-detect scheduler:
//               controller state encoding and session result codes.
// Revision    : 1.0 - initial release
// ============================================================================
package sym_sched_pkg;

    // Controller states; explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    // Session result codes
    localparam logic [1:0] RES_NOMATCH = 2'b00;
    localparam logic [1:0] RES_ABORT   = 2'b01;
    localparam logic [1:0] RES_ODD     = 2'b10;
    localparam logic [1:0] RES_EVEN    = 2'b11;

endpackage : sym_sched_pkg
`default_nettype wire

// File: rtl/sym_detect_sched_matcher.sv
`default_nettype none
// ============================================================================
// Module      : sym_window_matcher
// Description : Sliding-window pattern matcher. Keeps the last PAT_LEN symbols
//               (oldest in the MSBs) and flags a match on the window value that
//               includes the symbol being shifted in this cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sym_window_matcher #(
    parameter int                          SYM_W   = 3,
    parameter int                          PAT_LEN = 4,
    parameter logic [PAT_LEN*SYM_W-1:0]    PATTERN = 12'b000_110_000_110
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic [SYM_W-1:0] sym,
    output logic             match,
    output logic             last_lsb
);

    localparam int                WIN_W     = PAT_LEN * SYM_W;
    localparam int                FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

    logic [WIN_W-1:0]       r_window;
    logic [FILL_W-1:0]      r_fill;
    logic                   r_last_lsb;
    logic [WIN_W+SYM_W-1:0] w_shifted;
    logic [WIN_W-1:0]       w_next_window;
    logic [FILL_W-1:0]      w_next_fill;

    // New symbol enters at the LSB end; the oldest symbol falls off the top
    assign w_shifted     = {r_window, sym};
    assign w_next_window = w_shifted[WIN_W-1:0];
    assign w_next_fill   = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + FILL_W'(1);

    // Only a full window can match, and only on a cycle that shifts a symbol in
    assign match    = shift_en && (w_next_fill == FILL_FULL) && (w_next_window == PATTERN);
    assign last_lsb = shift_en ? sym[0] : r_last_lsb;

    // Window, fill count and last-symbol parity registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_window   <= '0;
            r_fill     <= '0;
            r_last_lsb <= 1'b0;
        end else if (clr) begin
            r_window   <= '0;
            r_fill     <= '0;
            r_last_lsb <= 1'b0;
        end else if (shift_en) begin
            r_window   <= w_next_window;
            r_fill     <= w_next_fill;
            r_last_lsb <= sym[0];
        end
    end

endmodule : sym_window_matcher
`default_nettype wire

// File: rtl/sym_detect_sched.sv
`default_nettype none
// ============================================================================
// Module      : sym_detect_sched
// Description : Round-robin scheduler sharing one sliding-window pattern
//               matcher among NREQ symbol-stream requesters. Each session
//               streams FRAME_LEN symbols and reports a tagged 2-bit result.
// Revision    : 1.0 - initial release
// ============================================================================
module sym_detect_sched
    import sym_sched_pkg::*;
#(
    parameter int                          NREQ      = 4,
    parameter int                          SYM_W     = 3,
    parameter int                          PAT_LEN   = 4,
    parameter logic [PAT_LEN*SYM_W-1:0]    PATTERN   = 12'b000_110_000_110,
    parameter int                          FRAME_LEN = 8,
    parameter int                          TIMEOUT   = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*SYM_W-1:0]    sym_in,
    input  logic [NREQ-1:0]          sym_valid,
    output logic [NREQ-1:0]          sym_ready,
    output logic [NREQ-1:0]          grant,
    output logic                     busy,
    output logic                     result_valid,
    output logic [$clog2(NREQ)-1:0]  result_id,
    output logic [1:0]               result_code
);

    localparam int              ID_W        = $clog2(NREQ);
    localparam logic [7:0]      FRAME_LAST  = 8'(FRAME_LEN);
    localparam logic [7:0]      TIMEOUT_C   = 8'(TIMEOUT);
    localparam logic [ID_W-1:0] LAST_ID     = ID_W'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT_LSB = NREQ'(1);

    state_t            r_state;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_gidx;
    logic [7:0]        r_sym_cnt;
    logic [7:0]        r_idle_cnt;
    logic              r_hit;
    logic [NREQ-1:0]   r_grant;
    logic              r_busy;
    logic              r_result_valid;
    logic [ID_W-1:0]   r_result_id;
    logic [1:0]        r_result_code;

    logic              w_any_req;
    logic [ID_W-1:0]   w_winner;
    logic [NREQ-1:0]   w_win_onehot;
    logic [SYM_W-1:0]  w_gsym;
    logic              w_gvalid;
    logic              w_greq;
    logic              w_accept;
    logic              w_match;
    logic              w_last_lsb;
    logic              w_hit_now;
    logic [7:0]        w_sym_cnt_nxt;
    logic [7:0]        w_idle_cnt_nxt;
    logic [ID_W-1:0]   w_next_ptr;

    // Round-robin pick: first set request scanning upward from r_ptr with wrap
    always_comb begin
        int              idx;
        logic [ID_W-1:0] sel;
        w_any_req = 1'b0;
        w_winner  = r_ptr;
        idx       = 0;
        sel       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(r_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            sel = ID_W'(idx);
            if (req[sel]) begin
                w_any_req = 1'b1;
                w_winner  = sel;
            end
        end
    end

    assign w_win_onehot   = ONE_HOT_LSB << w_winner;
    assign w_gsym         = sym_in[r_gidx*SYM_W +: SYM_W];
    assign w_gvalid       = sym_valid[r_gidx];
    assign w_greq         = req[r_gidx];
    assign w_accept       = (r_state == RUN) && w_gvalid;
    assign w_hit_now      = r_hit | w_match;
    assign w_sym_cnt_nxt  = r_sym_cnt + 8'd1;
    assign w_idle_cnt_nxt = r_idle_cnt + 8'd1;
    assign w_next_ptr     = (r_gidx == LAST_ID) ? '0 : r_gidx + ID_W'(1);

    sym_window_matcher #(
        .SYM_W   (SYM_W),
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_matcher (
        .clk      (clk),
        .rst      (rst),
        .clr      (r_state == IDLE),
        .shift_en (w_accept),
        .sym      (w_gsym),
        .match    (w_match),
        .last_lsb (w_last_lsb)
    );

    // Session controller: arbitration, symbol streaming and result reporting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_ptr          <= '0;
            r_gidx         <= '0;
            r_sym_cnt      <= '0;
            r_idle_cnt     <= '0;
            r_hit          <= 1'b0;
            r_grant        <= '0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_result_id    <= '0;
            r_result_code  <= RES_NOMATCH;
        end else begin
            case (r_state)
                IDLE: begin
                    r_result_valid <= 1'b0;
                    if (w_any_req) begin
                        r_state    <= RUN;
                        r_grant    <= w_win_onehot;
                        r_gidx     <= w_winner;
                        r_sym_cnt  <= '0;
                        r_idle_cnt <= '0;
                        r_hit      <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        // An accepted symbol wins over timeout and request drop
                        r_sym_cnt  <= w_sym_cnt_nxt;
                        r_idle_cnt <= '0;
                        r_hit      <= w_hit_now;
                        if (w_sym_cnt_nxt == FRAME_LAST) begin
                            r_state        <= REPORT;
                            r_result_valid <= 1'b1;
                            r_result_id    <= r_gidx;
                            r_result_code  <= w_hit_now ? {1'b1, ~w_last_lsb} : RES_NOMATCH;
                            r_grant        <= '0;
                            r_ptr          <= w_next_ptr;
                        end
                    end else begin
                        r_idle_cnt <= w_idle_cnt_nxt;
                        if (!w_greq || (w_idle_cnt_nxt >= TIMEOUT_C)) begin
                            r_state        <= REPORT;
                            r_result_valid <= 1'b1;
                            r_result_id    <= r_gidx;
                            r_result_code  <= RES_ABORT;
                            r_grant        <= '0;
                            r_ptr          <= w_next_ptr;
                        end
                    end
                end
                REPORT: begin
                    r_result_valid <= 1'b0;
                    r_busy         <= 1'b0;
                    r_state        <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant        = r_grant;
    assign sym_ready    = r_grant & {NREQ{r_state == RUN}};
    assign busy         = r_busy;
    assign result_valid = r_result_valid;
    assign result_id    = r_result_id;
    assign result_code  = r_result_code;

endmodule : sym_detect_sched
`default_nettype wire
